mash_ncl: RTL
=============

# mash_ncl

MASH 1-1-1 noise-cancellation and output stage of the delta-sigma modulator, directly downstream of the three chained error-feedback accumulator stages. It takes each stage's carry/quantize bit, time-aligns the bits across the pipelined chain, and forms the multi-bit correction y = c1 + (1−z⁻¹)c2 + (1−z⁻¹)²c3. It adds y to the integer divide word and drives a registered, saturated divider value to the fractional-N divider, with a warm-up valid flag.

## Interface
- P_INT_WIDTH, 8, width of integer divide word and of o_div
- P_FILL_CYCLES, 3, enabled cycles o_valid stays low after enable rise or order change
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  reset; asynchronous, active-low
- i_en  in  1  pipeline advance enable; same cycle as the upstream stages' enable
- i_order  in  2  modulator order: 0 = integer only, 1 = MASH-1, 2 = MASH-1-1, 3 = MASH-1-1-1
- i_q1  in  1  quantize bit of stage 1 (leads stage 3 by 2 cycles)
- i_q2  in  1  quantize bit of stage 2 (leads stage 3 by 1 cycle)
- i_q3  in  1  quantize bit of stage 3
- i_ncw_int  in  P_INT_WIDTH  integer part of the divide ratio, unsigned
- o_div  out  P_INT_WIDTH  registered divider value, unsigned
- o_valid  out  1  o_div carries a fully settled sequence
- o_sat  out  1  registered; o_div was clamped this cycle

## Operation
- Alignment shift registers, advanced only when i_en=1: q1_d1←i_q1, q1_d2←q1_d1; q2_d1←i_q2, q2_d2←q2_d1; q3_d1←i_q3, q3_d2←q3_d1.
- Aligned terms: c1=q1_d2; c2=q2_d1, c2d=q2_d2; c3=i_q3, c3d=q3_d1, c3dd=q3_d2.
- y is signed, 4 bits, range −3..+4:
  - order 0: y=0
  - order 1: y=c1
  - order 2: y=c1+c2−c2d
  - order 3: y=c1+c2−c2d+c3−2·c3d+c3dd
- Sum s = i_ncw_int + y, computed in P_INT_WIDTH+2 signed bits.
  - s<0: o_div←0, o_sat←1.
  - s>2^P_INT_WIDTH−1: o_div←all ones, o_sat←1.
  - Otherwise: o_div←s, o_sat←0.
- Output registers update only when i_en=1. i_ncw_int is sampled at the output register with no alignment delay.
- Warm-up FSM, with a down-counter of width ceil(log2(P_FILL_CYCLES+1)):
  - IDLE: i_en=0. o_valid=0, all registers hold. On i_en=1 → FILL, counter=P_FILL_CYCLES.
  - FILL: o_valid=0. Counter decrements on each enabled edge; reaching 0 → RUN.
  - RUN: o_valid=1.
  - i_en=0 in FILL or RUN → IDLE. Alignment registers keep their contents, and re-entry still refills.
- i_order change (compared with a registered copy) while in FILL or RUN → FILL with counter reloaded. This takes priority over the decrement in the same cycle.
- If i_en=0 and i_order changes on the same cycle: go to IDLE; the order copy still updates.

## Timing
- Reset values: o_div=0, o_valid=0, o_sat=0, all alignment registers 0, state IDLE, order copy=0.
- Reset asserted mid-operation clears everything immediately, asynchronously.
- Latency from input to o_div, counted in enabled edges: i_q3 = 1, i_q2 = 2, i_q1 = 3, i_ncw_int = 1.
- First o_valid=1 on the cycle after the P_FILL_CYCLES-th enabled edge following enable rise or order change.
- No backpressure; the block consumes one quantize triple per enabled cycle.

## Structure
- Shared package mash_pkg holds:
  - order encodings: ORDER_INT, ORDER_1, ORDER_2, ORDER_3
  - FSM state enum: IDLE, FILL, RUN
  - Y_WIDTH=4
  - constants Y_MIN=−3 and Y_MAX=4
- One sub-module, mash_diff: a 1-bit enabled delay line producing the current and previous taps, instanced for stages 2 and 3 (stage 3 chains two).
- Saturation and FSM stay in the top level.

## Test plan
- Reset check: assert i_rst_n=0 mid-RUN → o_div=0, o_valid=0, o_sat=0 asynchronously. After release with i_en=1, o_valid rises after exactly 3 enabled edges.
- Order 1, i_ncw_int=100, i_q1 held 1, i_q2=i_q3=0 → after fill, o_div=101 steadily. With i_q1 held 0 → 100.
- Order 3, i_ncw_int=100, i_q1=i_q2=0, single-cycle i_q3 pulse at edge t → o_div = 101, 98, 101, 100 at edges t+1..t+4.
- Order 2, i_ncw_int=100, single i_q2 pulse → o_div = 101 at t+2, 99 at t+3, then 100. The same stimulus at order 1 gives constant 100.
- Saturation:
  - Pattern producing y=−3 with i_ncw_int=1 → o_div=0, o_sat=1.
  - Pattern producing y=+4 with i_ncw_int=254 → o_div=255, o_sat=1.
  - i_ncw_int=251 with y=+4 → o_div=255, o_sat=0.
- Order change 3→2 in RUN → o_valid low for exactly 3 enabled cycles. Deasserting i_en mid-FILL holds all outputs, and the refill restarts on re-enable.

Source files
------------

// File: rtl/mash_pkg.sv
// ============================================================================
// mash_pkg : shared encodings and the noise-cancellation sum for the MASH NCL
// Revision : 1.0
// ============================================================================
`default_nettype none

package mash_pkg;

  localparam logic [1:0] ORDER_INT = 2'd0;
  localparam logic [1:0] ORDER_1   = 2'd1;
  localparam logic [1:0] ORDER_2   = 2'd2;
  localparam logic [1:0] ORDER_3   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int Y_WIDTH = 4;
  localparam logic signed [Y_WIDTH-1:0] Y_MIN = -4'sd3;
  localparam logic signed [Y_WIDTH-1:0] Y_MAX = 4'sd4;

  function automatic logic signed [Y_WIDTH-1:0] ext_bit(input logic b);
    return {{(Y_WIDTH-1){1'b0}}, b};
  endfunction

  // y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3, truncated to the selected order
  function automatic logic signed [Y_WIDTH-1:0] calc_y(
    input logic [1:0] order,
    input logic       c1,
    input logic       c2,
    input logic       c2d,
    input logic       c3,
    input logic       c3d,
    input logic       c3dd
  );
    logic signed [Y_WIDTH-1:0] t1;
    logic signed [Y_WIDTH-1:0] t2;
    logic signed [Y_WIDTH-1:0] t3;
    logic signed [Y_WIDTH-1:0] y;
    t1 = ext_bit(c1);
    t2 = ext_bit(c2) - ext_bit(c2d);
    t3 = ext_bit(c3) - (ext_bit(c3d) <<< 1) + ext_bit(c3dd);
    case (order)
      ORDER_INT: y = '0;
      ORDER_1:   y = t1;
      ORDER_2:   y = t1 + t2;
      ORDER_3:   y = t1 + t2 + t3;
      default:   y = '0;
    endcase
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mash_diff.sv
// ============================================================================
// mash_diff : 1-bit enabled delay tap exposing current and previous samples
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mash_diff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_bit,
  output logic o_cur,
  output logic o_prev
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_en ? i_bit : prev_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) prev_q <= 1'b0;
    else          prev_q <= prev_d;
  end

  assign o_cur  = i_bit;
  assign o_prev = prev_q;

endmodule

`default_nettype wire

// File: rtl/mash_ncl.sv
// ============================================================================
// mash_ncl : MASH 1-1-1 bit alignment, noise cancellation and saturated
//            divider output with warm-up valid tracking
// Revision : 1.0
// ============================================================================
`default_nettype none

module mash_ncl
  import mash_pkg::*;
#(
  parameter int P_INT_WIDTH   = 8,
  parameter int P_FILL_CYCLES = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [1:0]             i_order,
  input  logic                   i_q1,
  input  logic                   i_q2,
  input  logic                   i_q3,
  input  logic [P_INT_WIDTH-1:0] i_ncw_int,
  output logic [P_INT_WIDTH-1:0] o_div,
  output logic                   o_valid,
  output logic                   o_sat
);

  localparam int CNT_W = (P_FILL_CYCLES > 0) ? $clog2(P_FILL_CYCLES + 1) : 1;
  localparam int S_W   = P_INT_WIDTH + 2;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(P_FILL_CYCLES);
  localparam logic signed [S_W-1:0] DIV_MAX  = S_W'((64'd1 << P_INT_WIDTH) - 64'd1);

  // Stage 1 leads stage 3 by two cycles and stage 2 by one.
  logic q1_d1_q, q1_d1_d;
  logic q1_d2_q, q1_d2_d;
  logic q2_d1_q, q2_d1_d;

  logic c2, c2d, c3, c3d_a, c3d, c3dd;

  always_comb begin
    q1_d1_d = i_en ? i_q1    : q1_d1_q;
    q1_d2_d = i_en ? q1_d1_q : q1_d2_q;
    q2_d1_d = i_en ? i_q2    : q2_d1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q1_d1_q <= 1'b0;
      q1_d2_q <= 1'b0;
      q2_d1_q <= 1'b0;
    end else begin
      q1_d1_q <= q1_d1_d;
      q1_d2_q <= q1_d2_d;
      q2_d1_q <= q2_d1_d;
    end
  end

  mash_diff u_diff_s2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_bit   (q2_d1_q),
    .o_cur   (c2),
    .o_prev  (c2d)
  );

  mash_diff u_diff_s3a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_bit   (i_q3),
    .o_cur   (c3),
    .o_prev  (c3d_a)
  );

  mash_diff u_diff_s3b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_bit   (c3d_a),
    .o_cur   (c3d),
    .o_prev  (c3dd)
  );

  logic signed [Y_WIDTH-1:0] y;
  logic signed [S_W-1:0]     sum;

  always_comb begin
    y   = calc_y(i_order, q1_d2_q, c2, c2d, c3, c3d, c3dd);
    sum = $signed({2'b00, i_ncw_int}) + $signed({{(S_W-Y_WIDTH){y[Y_WIDTH-1]}}, y});
    assert (y >= Y_MIN && y <= Y_MAX);
  end

  logic [P_INT_WIDTH-1:0] div_q, div_d;
  logic                   sat_q, sat_d;

  always_comb begin
    div_d = div_q;
    sat_d = sat_q;
    if (i_en) begin
      if (sum[S_W-1]) begin
        div_d = '0;
        sat_d = 1'b1;
      end else if (sum > DIV_MAX) begin
        div_d = '1;
        sat_d = 1'b1;
      end else begin
        div_d = sum[P_INT_WIDTH-1:0];
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q <= '0;
      sat_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sat_q <= sat_d;
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       order_q;
  logic             valid_q, valid_d;
  logic             order_chg;

  always_comb begin
    order_chg = (i_order != order_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = (P_FILL_CYCLES == 0) ? RUN : FILL;
          cnt_d   = CNT_LOAD;
        end
        FILL, RUN: begin
          // A reload on order change wins over the normal countdown.
          if (order_chg) begin
            state_d = (P_FILL_CYCLES == 0) ? RUN : FILL;
            cnt_d   = CNT_LOAD;
          end else if (state_q == FILL) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      order_q <= ORDER_INT;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      order_q <= i_order;
      valid_q <= valid_d;
    end
  end

  assign o_div   = div_q;
  assign o_sat   = sat_q;
  assign o_valid = valid_q;

endmodule

`default_nettype wire
